// File: rtl/conv_result_pingpong_drain.sv
// Ping-pong capture of conv engine result frames, drained pixel-major over valid/ready.
// Build option: define CONV_RESULT_RELU_EN to clamp negative output elements to zero.
module conv_result_pingpong_drain #(
  parameter int DATA_WIDTH            = 8,
  parameter int RESULT_W              = 6,
  parameter int RESULT_H              = 6,
  parameter int RESULT_D              = 8,
  parameter int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W * RESULT_H)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_wraddress,
  input  logic [DATA_WIDTH*RESULT_D-1:0]            result_data_out,
  input  logic [RESULT_D-1:0]                       result_wren,
  output logic                                      frame_rdy,
  output logic [DATA_WIDTH*RESULT_D-1:0]            out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_last,
  output logic [1:0]                                err
);

  // state | meaning
  // IDLE  | waiting for bank_full[rd_bank]
  // FETCH | reading pixel p of rd_bank into out_data
  // VALID | presenting pixel p, waiting for out_ready
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  localparam int N  = RESULT_W * RESULT_H;
  localparam int AW = RESULT_RAM_ADDR_WIDTH;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [2][RESULT_D][N];

  logic                wr_bank;
  logic                rd_bank;
  logic [1:0]          bank_full;
  logic [AW-1:0]       wr_count;
  logic [AW-1:0]       p;
  logic [AW-1:0]       addr [RESULT_D];
  logic [RESULT_D-1:0] ch_ok;
  logic [RESULT_D-1:0] ch_oor;
  logic                bank_busy;
  logic                frame_done;
  logic                drain_done;
  logic                hs;

  function automatic logic [DATA_WIDTH-1:0] shape(input logic [DATA_WIDTH-1:0] v);
`ifdef CONV_RESULT_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    bank_busy = bank_full[wr_bank];
    ch_ok     = '0;
    ch_oor    = '0;
    for (int k = 0; k < RESULT_D; k++) begin
      addr[k]   = result_wraddress[k*AW +: AW];
      ch_oor[k] = result_wren[k] && !bank_busy && ({1'b0, addr[k]} >= (AW+1)'(N));
      ch_ok[k]  = result_wren[k] && !bank_busy && !ch_oor[k];
    end
  end

  // Channel 0 alone drives frame accounting; all channels write in lockstep.
  assign frame_done = ch_ok[0] && (wr_count == AW'(N - 1));
  assign hs         = (state == VALID) && out_ready;
  assign drain_done = hs && (p == AW'(N - 1));

  assign frame_rdy = !bank_full[wr_bank];
  assign out_valid = (state == VALID);
  assign out_last  = (state == VALID) && (p == AW'(N - 1));

  always_ff @(posedge clk) begin
    for (int k = 0; k < RESULT_D; k++) begin
      if (ch_ok[k]) mem[wr_bank][k][addr[k]] <= result_data_out[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank   <= 1'b0;
      wr_count  <= '0;
      bank_full <= 2'b00;
      err       <= 2'b00;
    end else begin
      if (frame_done) begin
        wr_count <= '0;
        wr_bank  <= ~wr_bank;
      end else if (ch_ok[0]) begin
        wr_count <= wr_count + AW'(1);
      end
      // Set and clear always target different banks, so both can land together.
      bank_full <= (bank_full & ~(drain_done ? (2'b01 << rd_bank) : 2'b00))
                 | (frame_done ? (2'b01 << wr_bank) : 2'b00);
      err[0] <= err[0] | (bank_busy && (|result_wren));
      err[1] <= err[1] | (|ch_oor);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      p        <= '0;
      rd_bank  <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE:  p <= '0;
        FETCH: begin
          for (int k = 0; k < RESULT_D; k++)
            out_data[k*DATA_WIDTH +: DATA_WIDTH] <= shape(mem[rd_bank][k][p]);
        end
        VALID: begin
          if (drain_done)  rd_bank <= ~rd_bank;
          else if (hs)     p <= p + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bank_full[rd_bank]) state_next = FETCH;
      FETCH:   state_next = VALID;
      VALID:   if (hs) state_next = drain_done ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_result_pingpong_drain.sv
// Directed bench for conv_result_pingpong_drain: cycle table for a basic frame plus corner sequences.
module tb_conv_result_pingpong_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  waddr = '0;
  logic [5:0]  waddr2 = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  wren = '0;
  logic        ready = 1'b0;

  logic        frame_rdy, out_valid, out_last;
  logic [15:0] out_data;
  logic [1:0]  err;
  logic        frame_rdy2, out_valid2, out_last2;
  logic [15:0] out_data2;
  logic [1:0]  err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_result_pingpong_drain #(.DATA_WIDTH(8), .RESULT_W(2), .RESULT_H(2), .RESULT_D(2)) dut (
    .clk(clk), .reset(reset), .result_wraddress(waddr), .result_data_out(wdata),
    .result_wren(wren), .frame_rdy(frame_rdy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(ready), .out_last(out_last), .err(err));

  // N=6 instance: a 3-bit address can exceed the frame, unlike the N=4 one.
  conv_result_pingpong_drain #(.DATA_WIDTH(8), .RESULT_W(3), .RESULT_H(2), .RESULT_D(2)) dut2 (
    .clk(clk), .reset(reset), .result_wraddress(waddr2), .result_data_out(wdata),
    .result_wren(wren), .frame_rdy(frame_rdy2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(ready), .out_last(out_last2), .err(err2));

  typedef struct {
    logic [1:0]  wren;
    logic [1:0]  addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        ready;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_last;
    logic        e_rdy;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d0, input logic [7:0] d1);
    wren   = 2'b11;
    waddr  = {a[1:0], a[1:0]};
    waddr2 = {a, a};
    wdata  = {d1, d0};
    tick();
    wren = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wren  = 2'b00;
    ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_valid_timeout"}, out_valid, 1);
  endtask

  task automatic expect_beat(input string nm, input logic [15:0] exp, input logic last);
    wait_valid(nm);
    check({nm, "_data"}, out_data, exp);
    check({nm, "_last"}, out_last, last);
    tick();
  endtask

  initial begin
    // Basic frame, cycle by cycle; row i drives the inputs sampled at edge i.
    for (int i = 0; i < 14; i++)
      vecs[i] = '{2'b00, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 2'b00};
    for (int i = 0; i < 4; i++) begin
      vecs[i].wren = 2'b11;
      vecs[i].addr = 2'(i);
      vecs[i].d0   = 8'(8'h10 + i);
      vecs[i].d1   = 8'(8'h20 + i);
    end
    vecs[5].e_valid = 1'b1; vecs[5].e_data = 16'h2010;
    vecs[6].e_data  = 16'h2010;
    vecs[7].e_valid = 1'b1; vecs[7].e_data = 16'h2111;
    vecs[8].e_data  = 16'h2111;
    vecs[9].e_valid = 1'b1; vecs[9].e_data = 16'h2212;
    vecs[10].e_data = 16'h2212;
    vecs[11].e_valid = 1'b1; vecs[11].e_data = 16'h2313; vecs[11].e_last = 1'b1;
    vecs[12].e_data = 16'h2313;
    vecs[13].e_data = 16'h2313;

    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 16'h0000);
    check("rst_err", err, 2'b00);
    check("rst_frame_rdy", frame_rdy, 1);
    check("rst_err_n6", err2, 2'b00);

    for (int i = 0; i < 14; i++) begin
      wren   = vecs[i].wren;
      waddr  = {vecs[i].addr, vecs[i].addr};
      waddr2 = {1'b0, vecs[i].addr, 1'b0, vecs[i].addr};
      wdata  = {vecs[i].d1, vecs[i].d0};
      ready  = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
      check($sformatf("vec%0d_last", i), out_last, vecs[i].e_last);
      check($sformatf("vec%0d_frame_rdy", i), frame_rdy, vecs[i].e_rdy);
      check($sformatf("vec%0d_err", i), err, vecs[i].e_err);
    end
    wren = 2'b00;

    // Backpressure on the second beat.
    do_reset();
    for (int i = 0; i < 4; i++) wr(3'(i), 8'(8'h10 + i), 8'(8'h20 + i));
    ready = 1'b1;
    expect_beat("bp_b0", 16'h2010, 0);
    ready = 1'b0;
    wait_valid("bp_b1");
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_hold%0d_valid", c), out_valid, 1);
      check($sformatf("bp_hold%0d_data", c), out_data, 16'h2111);
    end
    ready = 1'b1;
    expect_beat("bp_b1", 16'h2111, 0);
    expect_beat("bp_b2", 16'h2212, 0);
    expect_beat("bp_b3", 16'h2313, 1);

    // Two frames with no drain, then an overflow write.
    do_reset();
    for (int i = 0; i < 4; i++) wr(3'(i), 8'(8'h30 + i), 8'(8'h40 + i));
    check("pp_rdy_after_first", frame_rdy, 1);
    for (int i = 0; i < 4; i++) wr(3'(i), 8'(8'h50 + i), 8'(8'h60 + i));
    check("pp_rdy_after_second", frame_rdy, 0);
    check("pp_err_before_ovf", err, 2'b00);
    wr(3'd0, 8'hEE, 8'hEE);
    check("pp_err_ovf", err, 2'b01);
    check("pp_rdy_ovf", frame_rdy, 0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++)
      expect_beat($sformatf("pp_a%0d", i), 16'(16'h4030 + 16'h0101 * i), i == 3);
    check("pp_rdy_after_drain", frame_rdy, 1);
    for (int i = 0; i < 4; i++)
      expect_beat($sformatf("pp_b%0d", i), 16'(16'h6050 + 16'h0101 * i), i == 3);
    check("pp_err_sticky", err, 2'b01);

    // Out-of-range channel 0 write on the N=6 instance.
    do_reset();
    wren   = 2'b01;
    waddr  = 4'h0;
    waddr2 = {3'd0, 3'd7};
    wdata  = 16'h0099;
    tick();
    wren = 2'b00;
    check("oor_err", err2, 2'b10);
    check("oor_rdy", frame_rdy2, 1);
    for (int i = 0; i < 5; i++) wr(3'(i), 8'(8'h60 + i), 8'(8'h50 + i));
    for (int c = 0; c < 4; c++) tick();
    check("oor_no_drain_yet", out_valid2, 0);
    wr(3'd5, 8'h65, 8'h55);
    begin
      int n = 0;
      while (!out_valid2 && n < 10) begin
        tick();
        n++;
      end
    end
    check("oor_valid_timeout", out_valid2, 1);
    check("oor_b0_data", out_data2, 16'h5060);
    check("oor_b0_last", out_last2, 0);

    // Asynchronous reset in the middle of a stream.
    do_reset();
    for (int i = 0; i < 4; i++) wr(3'(i), 8'(8'h10 + i), 8'(8'h20 + i));
    ready = 1'b1;
    expect_beat("ar_b0", 16'h2010, 0);
    ready = 1'b0;
    wait_valid("ar_b1");
    check("ar_b1_data", out_data, 16'h2111);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_last", out_last, 0);
    check("ar_data", out_data, 16'h0000);
    check("ar_err", err, 2'b00);
    check("ar_frame_rdy", frame_rdy, 1);
    #2 reset = 1'b1;
    tick();
    check("ar_idle_after", out_valid, 0);
    for (int i = 0; i < 4; i++) wr(3'(i), 8'(8'h10 + i), 8'(8'h20 + i));
    ready = 1'b1;
    expect_beat("ar_new_b0", 16'h2010, 0);

    // Negative element on channel 0.
    do_reset();
    wr(3'd0, 8'h80, 8'h7F);
    for (int i = 1; i < 4; i++) wr(3'(i), 8'(i), 8'(i));
    ready = 1'b1;
`ifdef CONV_RESULT_RELU_EN
    expect_beat("relu_b0", 16'h7F00, 0);
`else
    expect_beat("relu_b0", 16'h7F80, 0);
`endif
    expect_beat("relu_b1", 16'h0101, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
